// File: rtl/case_conv_fifo_pkg.sv
// Shared constants for the case-converter datapath: ASCII letter bounds,
// the case bit, and the conversion mode encodings.
package case_conv_fifo_pkg;

  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;
  localparam logic [7:0] CASE_BIT = 8'h20;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_UPPER  = 2'd1,
    MODE_LOWER  = 2'd2,
    MODE_PASS   = 2'd3
  } conv_mode_e;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= UPPER_LO) && (c <= UPPER_HI);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= LOWER_LO) && (c <= LOWER_HI);
  endfunction

endpackage

// File: rtl/case_conv_fifo_ascii_case_map.sv
// Combinational ASCII case mapper; only letters are altered, every other
// byte value passes through unchanged.
module ascii_case_map
  import case_conv_fifo_pkg::*;
#(
  parameter int MODE = 0
) (
  input  logic [7:0] in,
  output logic [7:0] out
);

  localparam conv_mode_e MODE_SEL = conv_mode_e'(MODE[1:0]);

  logic upper;
  logic lower;

  assign upper = is_upper(in);
  assign lower = is_lower(in);

  always_comb begin
    out = in;
    case (MODE_SEL)
      MODE_TOGGLE: if (upper || lower) out = in ^ CASE_BIT;
      MODE_UPPER:  if (lower) out = in & ~CASE_BIT;
      MODE_LOWER:  if (upper) out = in | CASE_BIT;
      MODE_PASS:   out = in;
      default:     out = in;
    endcase
  end

endmodule

// File: rtl/case_conv_fifo.sv
// RX-to-TX buffer: edge-detects RX byte pulses, case-converts each byte and
// queues it in a first-word fall-through FIFO with a sticky overflow flag.
module case_conv_fifo
  import case_conv_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int MODE  = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        v_q;
  logic        rst_hold_q;
  logic [7:0]  mapped;
  logic        accept;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push;

  ascii_case_map #(.MODE(MODE)) u_map (
    .in  (i_data),
    .out (mapped)
  );

  // The first clock after reset only samples i_valid, so a level held
  // across reset is never mistaken for a fresh RX pulse.
  assign accept = i_valid && !v_q && !rst_hold_q;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = !empty && i_ready;
  assign push   = accept && (!full || pop);

  assign o_valid = !empty;
  assign o_data  = o_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign o_count = wr_ptr - rd_ptr;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= mapped;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      v_q        <= 1'b0;
      rst_hold_q <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      v_q        <= i_valid;
      rst_hold_q <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (accept && full && !pop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_case_conv_fifo.sv
// Directed self-checking bench for case_conv_fifo: toggle and upper-case
// instances share stimulus; mapper modes 2 and 3 are checked standalone.
module tb_case_conv_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  logic [7:0] o_data;
  logic       o_valid;
  logic [3:0] o_count;
  logic       o_overflow;

  logic [7:0] up_data;
  logic       up_valid;
  logic [3:0] up_count;
  logic       up_overflow;

  logic [7:0] map_in;
  logic [7:0] lo_out;
  logic [7:0] pass_out;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  case_conv_fifo #(.DEPTH(8), .MODE(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_count(o_count), .o_overflow(o_overflow)
  );

  case_conv_fifo #(.DEPTH(8), .MODE(1)) dut_up (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_data(up_data), .o_valid(up_valid), .i_ready(ready),
    .o_count(up_count), .o_overflow(up_overflow)
  );

  ascii_case_map #(.MODE(2)) map_lo   (.in(map_in), .out(lo_out));
  ascii_case_map #(.MODE(3)) map_pass (.in(map_in), .out(pass_out));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One RX pulse: valid high for 'hold' clocks then low for one clock.
  task automatic applyStimulus(input logic [7:0] b, input int hold);
    data  = b;
    valid = 1'b1;
    repeat (hold) step();
    valid = 1'b0;
    step();
  endtask

  function automatic logic [7:0] tog(input logic [7:0] c);
    if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A)) return c ^ 8'h20;
    return c;
  endfunction

  logic [7:0] t2_in  [6] = '{8'h7A, 8'h51, 8'h40, 8'h5B, 8'h60, 8'h7B};
  logic [7:0] t2_up  [6] = '{8'h5A, 8'h51, 8'h40, 8'h5B, 8'h60, 8'h7B};
  logic [7:0] t2_tog [6] = '{8'h5A, 8'h71, 8'h40, 8'h5B, 8'h60, 8'h7B};

  initial begin
    int pops;
    int sent;
    int got;
    int cyc;
    logic stalled;
    logic [7:0] held;
    logic [7:0] q[$];

    rst = 1'b1; valid = 1'b0; ready = 1'b0; data = 8'h00; map_in = 8'h00;
    step(); step();

    // Reset state
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_data", 32'(o_data), 32'h00);
    checkOutput("rst_count", 32'(o_count), 32'd0);
    checkOutput("rst_overflow", 32'(o_overflow), 32'd0);

    // Lower and pass-through mapper modes
    map_in = 8'h41; #1; checkOutput("lo_A", 32'(lo_out), 32'h61);
    map_in = 8'h5A; #1; checkOutput("lo_Z", 32'(lo_out), 32'h7A);
    map_in = 8'h7A; #1; checkOutput("lo_z", 32'(lo_out), 32'h7A);
    map_in = 8'h40; #1; checkOutput("lo_at", 32'(lo_out), 32'h40);
    map_in = 8'h5B; #1; checkOutput("lo_brk", 32'(lo_out), 32'h5B);
    map_in = 8'h61; #1; checkOutput("pass_a", 32'(pass_out), 32'h61);
    map_in = 8'h5A; #1; checkOutput("pass_Z", 32'(pass_out), 32'h5A);

    rst = 1'b0;
    step();

    // Long RX pulse yields exactly one byte
    ready = 1'b1;
    data  = 8'h61;
    valid = 1'b1;
    pops  = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) checkOutput("t1_first_data", 32'(o_data), 32'h41);
      if (o_valid) pops++;
      if (i == 4) valid = 1'b0;
    end
    checkOutput("t1_pops", 32'(pops), 32'd1);
    checkOutput("t1_valid_end", 32'(o_valid), 32'd0);
    checkOutput("t1_count_end", 32'(o_count), 32'd0);

    // Boundary characters through toggle and force-upper instances
    ready = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(t2_in[i], 1);
    checkOutput("t2_up_count", 32'(up_count), 32'd6);
    checkOutput("t2_count", 32'(o_count), 32'd6);
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("t2_up_data", 32'(up_data), 32'(t2_up[i]));
      checkOutput("t2_tog_data", 32'(o_data), 32'(t2_tog[i]));
      step();
    end
    checkOutput("t2_up_empty", 32'(up_valid), 32'd0);

    // Overflow: nine bytes into eight entries
    ready = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(8'(8'h41 + i), 1);
    checkOutput("t3_count_full", 32'(o_count), 32'd8);
    checkOutput("t3_overflow", 32'(o_overflow), 32'd1);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("t3_drain", 32'(o_data), 32'(8'h61 + k));
      step();
    end
    checkOutput("t3_empty", 32'(o_valid), 32'd0);
    checkOutput("t3_overflow_sticky", 32'(o_overflow), 32'd1);

    // Full FIFO with simultaneous accept and pop
    ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    checkOutput("t4_overflow_clr", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h41 + i), 1);
    checkOutput("t4_count_full", 32'(o_count), 32'd8);
    data = 8'h4A; valid = 1'b1; ready = 1'b1;
    step();
    valid = 1'b0;
    checkOutput("t4_count_hold", 32'(o_count), 32'd8);
    checkOutput("t4_no_overflow", 32'(o_overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("t4_drain", 32'(o_data), (k < 7) ? 32'(8'h62 + k) : 32'h6A);
      step();
    end
    checkOutput("t4_empty", 32'(o_valid), 32'd0);

    // Streaming with ready toggling; wraps the pointers
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
    while (got < 20 && cyc < 200) begin
      if (cyc % 2 == 0 && sent < 20) begin
        data  = 8'(8'h3C + sent * 3);
        valid = 1'b1;
        q.push_back(tog(data));
        sent++;
      end else begin
        valid = 1'b0;
      end
      ready = (cyc % 2 == 1);
      if (stalled) checkOutput("t5_stable", 32'(o_data), 32'(held));
      stalled = o_valid && !ready;
      held    = o_data;
      if (o_valid && ready && q.size() > 0) begin
        checkOutput("t5_data", 32'(o_data), 32'(q.pop_front()));
        got++;
      end
      step();
      cyc++;
    end
    valid = 1'b0;
    checkOutput("t5_received", 32'(got), 32'd20);

    // Asynchronous reset mid-clock with i_valid held high
    ready = 1'b0;
    applyStimulus(8'h31, 1);
    applyStimulus(8'h32, 1);
    data = 8'h33; valid = 1'b1;
    step();
    checkOutput("t6_count_pre", 32'(o_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_valid_async", 32'(o_valid), 32'd0);
    checkOutput("t6_count_async", 32'(o_count), 32'd0);
    checkOutput("t6_overflow_async", 32'(o_overflow), 32'd0);
    step();
    rst = 1'b0;
    data = 8'h70;
    step(); step(); step();
    checkOutput("t6_no_accept", 32'(o_count), 32'd0);
    valid = 1'b0;
    step();
    valid = 1'b1;
    step();
    valid = 1'b0;
    checkOutput("t6_reaccept_count", 32'(o_count), 32'd1);
    checkOutput("t6_reaccept_data", 32'(o_data), 32'h50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
